// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer
//
// Small synchronous transmit FIFO that sits directly upstream of the UART TX
// FSM and serializer. The system controller writes bytes into it. The buffer
// presents them one at a time on P_DATA, with a one-cycle Data_Valid strobe.
// A strobe is issued only while the transmitter is idle (busy low). The
// buffer then follows busy through the frame, so that each byte produces
// exactly one strobe.
//
// Parameters:
//   DATA_LENGTH  byte width (default 8)
//   DEPTH        number of FIFO entries; must be a power of two, >= 2
//
// Ports:
//   CLK         in   single clock, rising edge
//   RST         in   asynchronous reset, active low
//   WR_DATA     in   byte to enqueue
//   WR_EN       in   enqueue request; dropped while FULL
//   busy        in   high while a UART TX frame is in progress
//   P_DATA      out  registered byte presented to the transmitter
//   Data_Valid  out  registered one-cycle issue strobe
//   FULL        out  COUNT == DEPTH
//   EMPTY       out  COUNT == 0
//   COUNT       out  number of stored entries (one extra bit so DEPTH fits)
//
// Optional feature, enabled by defining UART_TX_BUF_OVERFLOW_EN:
//   OVF_CLR     in   clears OVERFLOW (a new overflow in the same cycle wins)
//   OVERFLOW    out  sticky flag, set by a write attempted while FULL
// When the macro is undefined, neither port exists and writes made while the
// FIFO is full are silently dropped.
//
// Issue FSM states:
//   state        | meaning
//   S_IDLE       | waiting for a stored byte and busy low; issues on that edge
//   S_ISSUE      | Data_Valid is high this cycle
//   S_WAIT_BUSY  | waiting up to four cycles for the transmitter to raise busy
//   S_WAIT_DONE  | frame in progress; waiting for busy to fall

module uart_tx_buffer #(
    parameter int DATA_LENGTH = 8,
    parameter int DEPTH       = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_LENGTH-1:0]   WR_DATA,
    input  logic                     WR_EN,
    input  logic                     busy,
`ifdef UART_TX_BUF_OVERFLOW_EN
    input  logic                     OVF_CLR,
    output logic                     OVERFLOW,
`endif
    output logic [DATA_LENGTH-1:0]   P_DATA,
    output logic                     Data_Valid,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   COUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    logic [DATA_LENGTH-1:0] mem [DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;

    state_t                 state;
    state_t                 state_nxt;
    logic [1:0]             tmo;
    logic [1:0]             tmo_nxt;
    logic                   dv_nxt;
    logic [DATA_LENGTH-1:0] pdata_nxt;

    logic                   push;
    logic                   pop;

    assign FULL  = (COUNT == CW'(DEPTH));
    assign EMPTY = (COUNT == '0);

    // The write decision uses the registered FULL only. A pop in the same
    // cycle therefore never frees a slot for this cycle's write.
    assign push = WR_EN && !FULL;

    // ------------------------------------------------------------------
    // Storage: the memory is intentionally not reset.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            COUNT  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   COUNT <= COUNT + CW'(1);
                2'b01:   COUNT <= COUNT - CW'(1);
                default: COUNT <= COUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            tmo        <= 2'd0;
            Data_Valid <= 1'b0;
            P_DATA     <= '0;
        end else begin
            state      <= state_nxt;
            tmo        <= tmo_nxt;
            Data_Valid <= dv_nxt;
            P_DATA     <= pdata_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM: next state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        tmo_nxt   = tmo;
        dv_nxt    = 1'b0;
        pdata_nxt = P_DATA;
        pop       = 1'b0;

        case (state)
            S_IDLE: begin
                if (!EMPTY && !busy) begin
                    pop       = 1'b1;
                    dv_nxt    = 1'b1;
                    pdata_nxt = mem[rd_ptr];
                    state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                tmo_nxt   = 2'd0;
                state_nxt = S_WAIT_BUSY;
            end

            // If the transmitter never acknowledges, give up after four
            // cycles. The byte has already been popped and counts as consumed.
            S_WAIT_BUSY: begin
                if (busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (tmo == 2'd3) begin
                    state_nxt = S_IDLE;
                end else begin
                    tmo_nxt = tmo + 2'd1;
                end
            end

            S_WAIT_DONE: begin
                if (!busy) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef UART_TX_BUF_OVERFLOW_EN
    // Set has priority over clear, so an overflow in the same cycle as a
    // clear is never lost.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            OVERFLOW <= 1'b0;
        end else if (WR_EN && FULL) begin
            OVERFLOW <= 1'b1;
        end else if (OVF_CLR) begin
            OVERFLOW <= 1'b0;
        end
    end
`endif

endmodule
